redmule_job_offloader: RTL and testbench

REDMULE_JOB_OFFLOADER -- requirements
Module: redmule_job_offloader

---
 rtl/redmule_job_offloader.sv | 209 ++++++++++++++++++++
 tb/tb_redmule_job_offloader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_job_offloader.sv
// Offloads one RedMulE job over the periph bus: acquire a context, write the job registers,
// trigger, then wait for the end-of-job event and report the context ID.
module redmule_job_offloader #(
  parameter int unsigned N_JOB_REGS   = 10,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned RETRY_CYCLES = 4,
  parameter int unsigned OFFLOADER_ID = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,

  input  logic                       job_valid_i,
  output logic                       job_ready_o,
  input  logic [N_JOB_REGS*32-1:0]   job_regs_i,

  output logic                       periph_req_o,
  input  logic                       periph_gnt_i,
  output logic [31:0]                periph_add_o,
  output logic                       periph_wen_o,
  output logic [3:0]                 periph_be_o,
  output logic [31:0]                periph_data_o,
  output logic [ID_WIDTH-1:0]        periph_id_o,

  input  logic                       periph_r_valid_i,
  input  logic [31:0]                periph_r_data_i,
  input  logic [ID_WIDTH-1:0]        periph_r_id_i,

  input  logic                       evt_i,

  output logic                       busy_o,
  output logic                       done_o,
  output logic [7:0]                 job_id_o
);

  localparam logic [ID_WIDTH-1:0] OwnId     = ID_WIDTH'(OFFLOADER_ID);
  localparam logic [4:0]          LastIdx   = 5'(N_JOB_REGS - 1);
  localparam logic [7:0]          RetryLast = 8'(RETRY_CYCLES - 1);

  localparam logic [31:0] AddrTrigger = 32'h0000_0000;
  localparam logic [31:0] AddrAcquire = 32'h0000_0004;
  localparam logic [31:0] AddrJobBase = 32'h0000_0040;

  typedef enum logic [3:0] {
    StIdle,
    StAcqReq,
    StAcqRsp,
    StBackoff,
    StWrReq,
    StWrRsp,
    StTrigReq,
    StTrigRsp,
    StWaitEvt,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  ctx_q, ctx_d;
  logic [7:0]  job_id_q, job_id_d;
  logic [31:0] buf_q [N_JOB_REGS];

  logic        rsp_ok;
  logic [31:0] wr_data;
  logic [31:0] wr_addr;

  // Only bit 31 (busy) and the low byte (context ID) of the ACQUIRE response matter.
  logic unused_rdata;
  assign unused_rdata = ^periph_r_data_i[30:8];

  // Responses tagged for another initiator are not ours to consume.
  assign rsp_ok = periph_r_valid_i && (periph_r_id_i == OwnId);

  assign wr_addr = AddrJobBase + {25'b0, idx_q, 2'b00};

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < N_JOB_REGS; i++) begin
      if (idx_q == i[4:0]) wr_data = buf_q[i];
    end
  end

  // Job buffer is a plain data store; its contents only matter after an accept.
  always_ff @(posedge clk_i) begin
    if (state_q == StIdle && job_valid_i) begin
      for (int i = 0; i < N_JOB_REGS; i++) begin
        buf_q[i] <= job_regs_i[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      retry_q  <= '0;
      ctx_q    <= '0;
      job_id_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      ctx_q    <= ctx_d;
      job_id_q <= job_id_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    ctx_d    = ctx_q;
    job_id_d = job_id_q;

    unique case (state_q)
      StIdle: begin
        if (job_valid_i) state_d = StAcqReq;
      end
      StAcqReq: begin
        if (periph_gnt_i) state_d = StAcqRsp;
      end
      StAcqRsp: begin
        if (rsp_ok) begin
          if (periph_r_data_i[31]) begin
            retry_d = '0;
            state_d = StBackoff;
          end else begin
            ctx_d   = periph_r_data_i[7:0];
            idx_d   = '0;
            state_d = StWrReq;
          end
        end
      end
      StBackoff: begin
        if (retry_q == RetryLast) begin
          state_d = StAcqReq;
        end else begin
          retry_d = retry_q + 8'd1;
        end
      end
      StWrReq: begin
        if (periph_gnt_i) state_d = StWrRsp;
      end
      StWrRsp: begin
        if (rsp_ok) begin
          idx_d   = idx_q + 5'd1;
          state_d = (idx_q == LastIdx) ? StTrigReq : StWrReq;
        end
      end
      StTrigReq: begin
        if (periph_gnt_i) state_d = StTrigRsp;
      end
      StTrigRsp: begin
        // An event coincident with this response is dropped by design.
        if (rsp_ok) state_d = StWaitEvt;
      end
      StWaitEvt: begin
        if (evt_i) begin
          job_id_d = ctx_q;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Request fields are a pure function of state and index, so they hold until the grant.
  always_comb begin
    periph_req_o  = 1'b0;
    periph_add_o  = '0;
    periph_wen_o  = 1'b0;
    periph_be_o   = '0;
    periph_data_o = '0;

    unique case (state_q)
      StAcqReq: begin
        periph_req_o = 1'b1;
        periph_add_o = AddrAcquire;
        periph_wen_o = 1'b1;
        periph_be_o  = 4'hF;
      end
      StWrReq: begin
        periph_req_o  = 1'b1;
        periph_add_o  = wr_addr;
        periph_be_o   = 4'hF;
        periph_data_o = wr_data;
      end
      StTrigReq: begin
        periph_req_o = 1'b1;
        periph_add_o = AddrTrigger;
        periph_be_o  = 4'hF;
      end
      default: begin
      end
    endcase
  end

  assign periph_id_o = OwnId;
  assign job_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign job_id_o    = job_id_q;

endmodule

// File: tb/tb_redmule_job_offloader.sv
// Directed bench for redmule_job_offloader: a hand-driven periph target with
// hand-computed addresses, data, context IDs and handshake timing.
module tb_redmule_job_offloader;

  localparam int unsigned NRegs = 10;

  logic               clk;
  logic               rst;
  logic               job_valid;
  logic               job_ready;
  logic [NRegs*32-1:0] job_regs;
  logic               req;
  logic               gnt;
  logic [31:0]        add;
  logic               wen;
  logic [3:0]         be;
  logic [31:0]        wdata;
  logic [7:0]         pid;
  logic               r_valid;
  logic [31:0]        r_data;
  logic [7:0]         r_id;
  logic               evt;
  logic               busy;
  logic               done;
  logic [7:0]         job_id;

  int total = 0;
  int bad   = 0;
  int acq_cnt;
  int waited;
  logic [31:0] exp_regs [NRegs];

  redmule_job_offloader #(
    .N_JOB_REGS  (NRegs),
    .ID_WIDTH    (8),
    .RETRY_CYCLES(4),
    .OFFLOADER_ID(0)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .job_valid_i     (job_valid),
    .job_ready_o     (job_ready),
    .job_regs_i      (job_regs),
    .periph_req_o    (req),
    .periph_gnt_i    (gnt),
    .periph_add_o    (add),
    .periph_wen_o    (wen),
    .periph_be_o     (be),
    .periph_data_o   (wdata),
    .periph_id_o     (pid),
    .periph_r_valid_i(r_valid),
    .periph_r_data_i (r_data),
    .periph_r_id_i   (r_id),
    .evt_i           (evt),
    .busy_o          (busy),
    .done_o          (done),
    .job_id_o        (job_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, check its fields, optionally stall the grant,
  // then return a response one cycle after the grant.
  task automatic serve(input logic [31:0] e_add, input logic e_wen, input logic [31:0] e_data,
                       input int gdly, input logic [31:0] rdata, input bit foreign,
                       input bit evt_co, output int w);
    w = 0;
    while (!req && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_seen", {31'b0, req}, 32'd1);
    if (req && add == 32'h4) acq_cnt++;
    check("req_add", add, e_add);
    check("req_wen", {31'b0, wen}, {31'b0, e_wen});
    check("req_be", {28'b0, be}, 32'hF);
    check("req_data", wdata, e_data);
    check("req_id", {24'b0, pid}, 32'h0);
    for (int k = 0; k < gdly; k++) begin
      @(negedge clk);
      check("stall_req", {31'b0, req}, 32'd1);
      check("stall_add", add, e_add);
      check("stall_data", wdata, e_data);
    end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    check("req_drop", {31'b0, req}, 32'd0);
    r_data = rdata;
    r_valid = 1'b1;
    if (foreign) begin
      r_id = 8'h5A;
      @(negedge clk);
      check("foreign_hold", {31'b0, req}, 32'd0);
      check("foreign_busy", {31'b0, busy}, 32'd1);
      r_id = 8'h00;
    end
    evt = evt_co;
    @(negedge clk);
    r_valid = 1'b0;
    evt = 1'b0;
  endtask

  task automatic run_job(input logic [7:0] ctx, input int n_busy, input int bp_idx,
                         input int filt_idx, input bit early_evt, input logic [31:0] seed,
                         input logic [7:0] prev_id);
    for (int i = 0; i < NRegs; i++) begin
      exp_regs[i] = seed + 32'(i) * 32'h0101_1111;
      job_regs[i*32 +: 32] = exp_regs[i];
    end
    check("ready_idle", {31'b0, job_ready}, 32'd1);
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    job_regs = {NRegs{32'hDEAD_BEEF}};
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    check("ready_after_accept", {31'b0, job_ready}, 32'd0);
    acq_cnt = 0;
    for (int b = 0; b < n_busy; b++) begin
      serve(32'h4, 1'b1, 32'h0, 0, 32'h8000_0000, 1'b0, 1'b0, waited);
      if (b > 0) check("retry_gap", {31'b0, waited >= 4}, 32'd1);
    end
    serve(32'h4, 1'b1, 32'h0, 0, {24'h0, ctx}, 1'b0, 1'b0, waited);
    if (n_busy > 0) check("retry_gap_last", {31'b0, waited >= 4}, 32'd1);
    check("acq_count", acq_cnt, n_busy + 1);
    if (early_evt) begin
      check("early_in_wrreq", {31'b0, req}, 32'd1);
      evt = 1'b1;
      @(negedge clk);
      evt = 1'b0;
    end
    for (int i = 0; i < NRegs; i++) begin
      serve(32'h40 + 32'(4 * i), 1'b0, exp_regs[i], (i == bp_idx) ? 5 : 0, 32'h0,
            i == filt_idx, 1'b0, waited);
    end
    serve(32'h0, 1'b0, 32'h0, 0, 32'h0, 1'b0, early_evt, waited);
    for (int k = 0; k < 3; k++) begin
      check("wait_no_done", {31'b0, done}, 32'd0);
      check("wait_no_req", {31'b0, req}, 32'd0);
      check("wait_job_id", {24'b0, job_id}, {24'b0, prev_id});
      @(negedge clk);
    end
    evt = 1'b1;
    @(negedge clk);
    evt = 1'b0;
    check("done_pulse", {31'b0, done}, 32'd1);
    check("done_job_id", {24'b0, job_id}, {24'b0, ctx});
    @(negedge clk);
    check("done_drop", {31'b0, done}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_ready", {31'b0, job_ready}, 32'd1);
    check("idle_job_id", {24'b0, job_id}, {24'b0, ctx});
  endtask

  initial begin
    rst = 1'b1;
    job_valid = 1'b0;
    job_regs = '0;
    gnt = 1'b0;
    r_valid = 1'b0;
    r_data = '0;
    r_id = '0;
    evt = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ready", {31'b0, job_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_add", add, 32'h0);
    check("rst_data", wdata, 32'h0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_job_id", {24'b0, job_id}, 32'h0);

    // Nominal job, context 0x03.
    run_job(8'h03, 0, -1, -1, 1'b0, 32'h1000_0000, 8'h00);
    // Two busy ACQUIREs then context 0x01.
    run_job(8'h01, 2, -1, -1, 1'b0, 32'h2000_0000, 8'h03);
    // Grant stalled on the 4th write; foreign response during the 6th write.
    run_job(8'h22, 0, 3, 5, 1'b0, 32'h3000_0000, 8'h01);
    // Early event in WR_REQ, event coincident with trigger response.
    run_job(8'h44, 0, -1, -1, 1'b1, 32'h4000_0000, 8'h22);

    // Reset while a write response is outstanding.
    for (int i = 0; i < NRegs; i++) job_regs[i*32 +: 32] = 32'h5000_0000 + 32'(i);
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    serve(32'h4, 1'b1, 32'h0, 0, 32'h7, 1'b0, 1'b0, waited);
    serve(32'h40, 1'b0, 32'h5000_0000, 0, 32'h0, 1'b0, 1'b0, waited);
    check("mid_req", {31'b0, req}, 32'd1);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    check("mid_wrrsp", {31'b0, req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_ready", {31'b0, job_ready}, 32'd1);
    check("midrst_req", {31'b0, req}, 32'd0);
    check("midrst_job_id", {24'b0, job_id}, 32'h0);
    r_valid = 1'b1;
    r_data = 32'h0;
    r_id = 8'h00;
    @(negedge clk);
    r_valid = 1'b0;
    check("stale_busy", {31'b0, busy}, 32'd0);
    check("stale_req", {31'b0, req}, 32'd0);
    check("stale_ready", {31'b0, job_ready}, 32'd1);

    // Fresh job after the abandoned one.
    run_job(8'h0C, 0, -1, -1, 1'b0, 32'h6000_0000, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
